// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I pipeline: datapath widths, ALU opcodes and
// forwarding-select encodings used by the execute stage and its hazard unit.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/execute_cycle_if.sv
// D->E inputs, hazard-unit controls and E->M outputs of the execute stage.
// master = the surrounding pipeline, slave = execute_cycle.
interface execute_cycle_if #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
);

  logic                  RegWriteE;
  logic                  ALUSrcE;
  logic                  MemWriteE;
  logic                  ResultSrcE;
  logic                  BranchE;
  logic [2:0]            ALUControlE;
  logic [XLEN-1:0]       RD1_E;
  logic [XLEN-1:0]       RD2_E;
  logic [XLEN-1:0]       Imm_Ext_E;
  logic [REG_ADDR_W-1:0] RD_E;
  logic [XLEN-1:0]       PCE;
  logic [XLEN-1:0]       PCPlus4E;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic [XLEN-1:0]       ALUResultM_fwd;
  logic [XLEN-1:0]       ResultW;
  logic                  HoldM;
  logic                  FlushM;

  logic                  PCSrcE;
  logic [XLEN-1:0]       PCTargetE;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic                  ResultSrcM;
  logic [REG_ADDR_W-1:0] RD_M;
  logic [XLEN-1:0]       ALUResultM;
  logic [XLEN-1:0]       WriteDataM;
  logic [XLEN-1:0]       PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ALUResultM_fwd, ResultW, HoldM, FlushM,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ALUResultM_fwd, ResultW, HoldM, FlushM,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub/and/or/slt, modulo 2^XLEN, plus a zero flag
// used for beq resolution. Unassigned opcodes produce zero.
module alu #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  import riscv_pkg::*;

  logic a_lt_b;

  assign a_lt_b = $signed(A) < $signed(B);

  always_comb begin
    // NOTE: combinational logic uses blocking '=', and Result gets a default
    // before the case so every path assigns it and no latch is inferred.
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, a_lt_b};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and branch target,
// followed by the E->M pipeline register with hold and bubble-flush controls.
module execute_cycle #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  execute_cycle_if.slave bus
);

  import riscv_pkg::*;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [XLEN-1:0]       pc_plus4;
  } em_t;

  // Select 11 is unused by the hazard unit and falls back to the register value.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] w_val,
    input logic [XLEN-1:0] m_val
  );
    case (sel)
      FWD_W:   return w_val;
      FWD_M:   return m_val;
      default: return reg_val;
    endcase
  endfunction

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  em_t             em_d;
  em_t             em_q;

  assign src_a = fwd_pick(bus.ForwardAE, bus.RD1_E, bus.ResultW, bus.ALUResultM_fwd);
  assign fwd_b = fwd_pick(bus.ForwardBE, bus.RD2_E, bus.ResultW, bus.ALUResultM_fwd);
  assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (bus.ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  // Branch decision and target go straight to fetch, independent of the E->M register.
  assign bus.PCSrcE    = bus.BranchE & alu_zero;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Store data is the forwarded rs2 value, never the immediate.
  assign em_d = '{
    reg_write:  bus.RegWriteE,
    mem_write:  bus.MemWriteE,
    result_src: bus.ResultSrcE,
    rd:         bus.RD_E,
    alu_result: alu_result,
    write_data: fwd_b,
    pc_plus4:   bus.PCPlus4E
  };

  // NOTE: state updates use non-blocking '<='; the asynchronous reset clears
  // every field because a stale RegWrite/MemWrite would corrupt architectural state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q <= '0;
    end else if (bus.FlushM) begin
      em_q <= '0;
    end else if (!bus.HoldM) begin
      em_q <= em_d;
    end
  end

  assign bus.RegWriteM  = em_q.reg_write;
  assign bus.MemWriteM  = em_q.mem_write;
  assign bus.ResultSrcM = em_q.result_src;
  assign bus.RD_M       = em_q.rd;
  assign bus.ALUResultM = em_q.alu_result;
  assign bus.WriteDataM = em_q.write_data;
  assign bus.PCPlus4M   = em_q.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed scenarios plus randomized
// traffic compared against an arithmetic reference model of the execute stage.
module tb_execute_cycle;

  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  execute_cycle_if bus ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } m_t;

  m_t exp_m;

  // ---------------- reference model ----------------
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] bias;
    bias = 32'h8000_0000;
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    // signed compare via sign-bias, then unsigned compare
    if (op == 3'd5) return ((a ^ bias) < (b ^ bias)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_fb();
    return pick(bus.ForwardBE, bus.RD2_E, bus.ResultW, bus.ALUResultM_fwd);
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] a, b;
    a = pick(bus.ForwardAE, bus.RD1_E, bus.ResultW, bus.ALUResultM_fwd);
    b = bus.ALUSrcE ? bus.Imm_Ext_E : model_fb();
    return ref_alu(bus.ALUControlE, a, b);
  endfunction

  function automatic logic model_pcsrc();
    return bus.BranchE && (model_result() == 32'd0);
  endfunction

  function automatic m_t predict();
    m_t n;
    if (bus.FlushM) return '0;
    if (bus.HoldM) return exp_m;
    n.rw  = bus.RegWriteE;
    n.mw  = bus.MemWriteE;
    n.rs  = bus.ResultSrcE;
    n.rd  = bus.RD_E;
    n.alu = model_result();
    n.wd  = model_fb();
    n.pc4 = bus.PCPlus4E;
    return n;
  endfunction

  function automatic m_t actual_m();
    return {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M,
            bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    bus.RegWriteE = 0; bus.ALUSrcE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.BranchE = 0; bus.ALUControlE = 3'd0; bus.RD1_E = 0; bus.RD2_E = 0;
    bus.Imm_Ext_E = 0; bus.RD_E = 0; bus.PCE = 0; bus.PCPlus4E = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUResultM_fwd = 0; bus.ResultW = 0;
    bus.HoldM = 0; bus.FlushM = 0;
  endtask

  task automatic randomize_inputs();
    bus.RegWriteE = 1'($urandom); bus.ALUSrcE = 1'($urandom);
    bus.MemWriteE = 1'($urandom); bus.ResultSrcE = 1'($urandom);
    bus.BranchE = 1'($urandom); bus.ALUControlE = 3'($urandom_range(0, 7));
    bus.RD1_E = $urandom; bus.RD2_E = ($urandom_range(0, 3) == 0) ? bus.RD1_E : $urandom;
    bus.Imm_Ext_E = $urandom; bus.RD_E = 5'($urandom);
    bus.PCE = $urandom; bus.PCPlus4E = bus.PCE + 32'd4;
    bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
    bus.ALUResultM_fwd = $urandom; bus.ResultW = $urandom;
  endtask

  // Predict the E->M register for the coming edge, then sample #1 after it.
  task automatic step();
    exp_m = predict();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL reset_state got=%h exp=%h", actual_m(), m_t'(0)); end
    checks++; if (bus.PCSrcE !== 1'b0) begin failures++;
      $display("FAIL reset_pcsrc got=%b exp=0", bus.PCSrcE); end
    @(posedge clk); #1;
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL reset_held got=%h exp=0", actual_m()); end
    #2 rst = 0;
    // outputs stay zero until the first capturing edge
    randomize_inputs();
    bus.HoldM = 1;
    #1;
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL reset_release got=%h exp=0", actual_m()); end
    step();
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL reset_hold_after_release got=%h exp=0", actual_m()); end
    clear_inputs();
  endtask

  task automatic test_add_imm();
    clear_inputs();
    bus.ALUControlE = ALU_ADD; bus.ALUSrcE = 1; bus.RD1_E = 5; bus.Imm_Ext_E = 7;
    bus.RD_E = 3; bus.RegWriteE = 1; bus.PCPlus4E = 32'h104;
    step();
    checks++; if (bus.ALUResultM !== 32'd12) begin failures++;
      $display("FAIL add_imm_result got=%0d exp=12", bus.ALUResultM); end
    checks++; if (bus.RD_M !== 5'd3 || bus.RegWriteM !== 1'b1) begin failures++;
      $display("FAIL add_imm_rd got rd=%0d rw=%b exp rd=3 rw=1", bus.RD_M, bus.RegWriteM); end
    checks++; if (actual_m() !== exp_m) begin failures++;
      $display("FAIL add_imm_state got=%h exp=%h", actual_m(), exp_m); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.ForwardAE = FWD_M; bus.ALUResultM_fwd = 100; bus.ForwardBE = FWD_W;
    bus.ResultW = 30; bus.ALUControlE = ALU_SUB; bus.RD1_E = 1; bus.RD2_E = 2;
    step();
    checks++; if (bus.ALUResultM !== 32'd70) begin failures++;
      $display("FAIL fwd_sub got=%0d exp=70", bus.ALUResultM); end
    bus.MemWriteE = 1; bus.ALUSrcE = 1; bus.Imm_Ext_E = 5;
    step();
    checks++; if (bus.WriteDataM !== 32'd30 || bus.MemWriteM !== 1'b1) begin failures++;
      $display("FAIL fwd_store got wd=%0d mw=%b exp wd=30 mw=1", bus.WriteDataM, bus.MemWriteM); end
    checks++; if (bus.ALUResultM !== 32'd95) begin failures++;
      $display("FAIL fwd_store_addr got=%0d exp=95", bus.ALUResultM); end
    // select 11 falls back to the register value
    bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b11; bus.ALUSrcE = 0;
    bus.RD1_E = 50; bus.RD2_E = 8;
    step();
    checks++; if (bus.ALUResultM !== 32'd42 || bus.WriteDataM !== 32'd8) begin failures++;
      $display("FAIL fwd_sel11 got alu=%0d wd=%0d exp alu=42 wd=8", bus.ALUResultM, bus.WriteDataM); end
  endtask

  task automatic test_beq();
    clear_inputs();
    bus.BranchE = 1; bus.ALUControlE = ALU_SUB; bus.RD1_E = 9; bus.RD2_E = 9;
    bus.PCE = 32'h40; bus.Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    checks++; if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h38) begin failures++;
      $display("FAIL beq_taken got src=%b tgt=%h exp src=1 tgt=38", bus.PCSrcE, bus.PCTargetE); end
    bus.RD2_E = 8;
    #1;
    checks++; if (bus.PCSrcE !== 1'b0) begin failures++;
      $display("FAIL beq_not_taken got=%b exp=0", bus.PCSrcE); end
    // hold/flush do not gate the combinational branch outputs
    bus.RD2_E = 9; bus.HoldM = 1; bus.FlushM = 1;
    #1;
    checks++; if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h38) begin failures++;
      $display("FAIL beq_under_flush got src=%b tgt=%h exp src=1 tgt=38", bus.PCSrcE, bus.PCTargetE); end
    step();
  endtask

  task automatic test_slt();
    clear_inputs();
    bus.ALUControlE = ALU_SLT; bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 1;
    step();
    checks++; if (bus.ALUResultM !== 32'd1) begin failures++;
      $display("FAIL slt_neg_lt_pos got=%h exp=1", bus.ALUResultM); end
    bus.RD1_E = 1; bus.RD2_E = 32'hFFFF_FFFF;
    step();
    checks++; if (bus.ALUResultM !== 32'd0) begin failures++;
      $display("FAIL slt_pos_lt_neg got=%h exp=0", bus.ALUResultM); end
  endtask

  task automatic test_hold();
    m_t held;
    clear_inputs();
    bus.RegWriteE = 1; bus.RD_E = 9; bus.RD1_E = 21; bus.RD2_E = 4;
    bus.ALUControlE = ALU_OR; bus.PCPlus4E = 32'h200;
    step();
    held = exp_m;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      bus.HoldM = 1; bus.FlushM = 0;
      step();
      checks++; if (actual_m() !== held) begin failures++;
        $display("FAIL hold_cycle%0d got=%h exp=%h", i, actual_m(), held); end
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    randomize_inputs();
    step();
    randomize_inputs();
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.FlushM = 1;
    step();
    checks++; if (bus.RegWriteM !== 1'b0 || bus.MemWriteM !== 1'b0 || bus.ALUResultM !== 32'd0) begin
      failures++;
      $display("FAIL flush_bubble got rw=%b mw=%b alu=%h exp 0/0/0", bus.RegWriteM, bus.MemWriteM, bus.ALUResultM); end
    randomize_inputs();
    bus.RegWriteE = 1; bus.ALUControlE = ALU_ADD; bus.RD1_E = 3;
    step();
    randomize_inputs();
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.FlushM = 1; bus.HoldM = 1;
    step();
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL flush_and_hold got=%h exp=0", actual_m()); end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.ResultSrcE = 1; bus.RD_E = 7;
    bus.RD1_E = 11; bus.RD2_E = 22; bus.PCPlus4E = 32'h88;
    step();
    checks++; if (actual_m() !== exp_m) begin failures++;
      $display("FAIL async_preload got=%h exp=%h", actual_m(), exp_m); end
    #2 rst = 1;
    exp_m = '0;
    #1;
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL async_immediate got=%h exp=0", actual_m()); end
    @(posedge clk); #1;
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL async_held got=%h exp=0", actual_m()); end
    #2 rst = 0;
    #1;
    checks++; if (actual_m() !== '0) begin failures++;
      $display("FAIL async_release got=%h exp=0", actual_m()); end
    step();
    checks++; if (actual_m() !== exp_m || bus.RD_M !== 5'd7) begin failures++;
      $display("FAIL async_recapture got=%h exp=%h", actual_m(), exp_m); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      bus.HoldM  = ($urandom_range(0, 5) == 0);
      bus.FlushM = ($urandom_range(0, 6) == 0);
      #1;
      checks++; if (bus.PCSrcE !== model_pcsrc() || bus.PCTargetE !== bus.PCE + bus.Imm_Ext_E) begin
        failures++;
        $display("FAIL rand_branch[%0d] got src=%b tgt=%h exp src=%b tgt=%h", i, bus.PCSrcE,
                 bus.PCTargetE, model_pcsrc(), bus.PCE + bus.Imm_Ext_E); end
      step();
      checks++; if (actual_m() !== exp_m) begin failures++;
        $display("FAIL rand_m[%0d] got=%h exp=%h", i, actual_m(), exp_m); end
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    exp_m = '0;
    #3;
    test_reset();
    test_add_imm();
    test_forwarding();
    test_beq();
    test_slt();
    test_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipelined core; consumes the D->E pipeline register outputs of decode_cycle.
- Resolves operand forwarding, performs the ALU operation, resolves beq and computes the branch target.
- Registers results into the E->M pipeline register feeding memory_cycle.
- Supports a hold (stall) and a flush (bubble) on the E->M register for the hazard unit.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- RegWriteE  in  1  register-file write enable from decode
- ALUSrcE  in  1  0: SrcB = forwarded RD2, 1: SrcB = Imm_Ext_E
- MemWriteE  in  1  data-memory write enable
- ResultSrcE  in  1  0: ALU result, 1: memory read data (in writeback)
- BranchE  in  1  instruction is beq
- ALUControlE  in  3  ALU opcode
- RD1_E, RD2_E  in  XLEN  register-file read data
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  REG_ADDR_W  destination register index
- PCE, PCPlus4E  in  XLEN  instruction PC and PC+4
- ForwardAE, ForwardBE  in  2  forwarding selects from hazard unit
- ALUResultM_fwd  in  XLEN  forwarded value from the M stage
- ResultW  in  XLEN  forwarded value from the W stage
- HoldM  in  1  hold the E->M register
- FlushM  in  1  load a bubble into the E->M register
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  branch target PCE + Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered control
- RD_M  out  REG_ADDR_W  registered destination index
- ALUResultM  out  XLEN  registered ALU result
- WriteDataM  out  XLEN  registered store data (forwarded RD2)
- PCPlus4M  out  XLEN  registered PC+4

Behaviour:
- Forwarding selects (same for A and B):
  - 00: register value (RD1_E / RD2_E)
  - 01: ResultW
  - 10: ALUResultM_fwd
  - 11: treated as 00
- SrcA = forwarded A.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteData is forwarded B, never the immediate.
- ALU opcodes; all arithmetic is modulo 2^XLEN with no overflow flag:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt (signed compare; result is 32'h1 or 32'h0)
  - any other code: result 0
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + Imm_Ext_E, wrapping modulo 2^XLEN.
- PCSrcE and PCTargetE are purely combinational: zero-cycle latency, unaffected by HoldM and FlushM.
- E->M register, one-cycle latency, per rising edge in priority order:
  1. rst high (asynchronous, immediate): all M outputs = 0.
  2. FlushM = 1: RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0, RD_M = 0, data fields = 0. This is a bubble.
  3. HoldM = 1: all M outputs keep their value.
  4. Otherwise: capture the E-stage values.
- FlushM and HoldM both high: flush wins.
- Reset asserted mid-operation clears outputs immediately, regardless of clock.
- Outputs stay 0 after deassertion until the first capturing edge.
- A bubble must never write the register file or memory.

Decomposition:
- Package riscv_pkg:
  - ALU opcode constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - forward-select constants FWD_REG, FWD_W, FWD_M
  - XLEN localparam
- Sub-module alu:
  - inputs A, B, ALUControl
  - outputs Result, Zero
  - purely combinational
  - instantiated once

Test Plan:
- Add immediate: ALUControlE=000, ALUSrcE=1, RD1_E=5, Imm_Ext_E=7, RD_E=3, RegWriteE=1 -> next edge ALUResultM=12, RD_M=3, RegWriteM=1.
- Forwarding and store data:
  - ForwardAE=10, ALUResultM_fwd=100, ForwardBE=01, ResultW=30, ALUControlE=001 -> ALUResultM=70.
  - Same with MemWriteE=1, ALUSrcE=1 -> WriteDataM=30.
- beq: BranchE=1, ALUControlE=001, RD1_E=RD2_E=9, PCE=32'h40, Imm_Ext_E=32'hFFFFFFF8 -> PCSrcE=1, PCTargetE=32'h38 same cycle. With RD2_E=8 -> PCSrcE=0.
- slt signed: RD1_E=32'hFFFFFFFF, RD2_E=1, ALUControlE=101 -> ALUResultM=1. Swap operands -> 0.
- Hold and flush:
  - HoldM=1 for 2 cycles with changing inputs -> M outputs unchanged.
  - FlushM=1 with RegWriteE=1 and MemWriteE=1 -> RegWriteM=0, MemWriteM=0, ALUResultM=0.
  - FlushM=1 and HoldM=1 together -> bubble.
- Async reset: assert rst between clock edges while M outputs are nonzero -> all M outputs 0 immediately, and still 0 on the next edge while rst is held.
